uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- UART transmitter: serialises one byte per request into start / 8 data (LSB first) / optional parity / stop.
- Runs on the same oversampled clock as the UART receiver. Each serial bit is held for Prescale clock cycles, so both ends share one Prescale setting.
- Sits between the system-side data source (valid-only request, Busy back-pressure) and the TX pad.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PRESCALE_WIDTH, 6, width of the Prescale input and the edge counter.

Ports:
- CLK  input  1  system/oversampling clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- P_DATA  input  DATA_WIDTH  parallel byte to send.
- Data_Valid  input  1  request; accepted only when Busy=0.
- PAR_EN  input  1  1 = parity bit inserted.
- PAR_TYP  input  1  0 = even, 1 = odd.
- Prescale  input  PRESCALE_WIDTH  clock cycles per serial bit.
- TX_OUT  output  1  serial line; idles high.
- Busy  output  1  high from accept until the frame ends.

Behaviour:
- Reset (RST low, asynchronous): state=IDLE, TX_OUT=1, Busy=0, counters=0, shift/config registers=0.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- IDLE: TX_OUT=1, Busy=0.
  - Data_Valid=1 at a rising edge: latch P_DATA, PAR_EN, PAR_TYP and Prescale.
  - Next cycle: state=START, TX_OUT=0, Busy=1 (latency 1 cycle from accept).
  - Data_Valid while Busy=1 is ignored; no queueing.
- Bit timing: edge counter counts 0..P-1, where P is the latched Prescale. The bit ends when edge_cnt >= P-1, then edge_cnt returns to 0.
  - P=0 or P=1 both give 1 cycle per bit.
  - A Prescale change mid-frame has no effect.
- START: 1 bit time of TX_OUT=0, then DATA.
- DATA: 8 bit times, LSB first; bit counter 0..7.
  - After bit 7: go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: 1 bit time. Value = XOR of latched data (even), inverted for odd.
- STOP: 1 bit time of TX_OUT=1, then IDLE with Busy=0 on the following cycle.
  - Minimum one idle cycle between frames.
- Frame length: (10 + PAR_EN) × P cycles with Busy=1.
- Reset mid-frame: immediate abort. TX_OUT=1, Busy=0; no partial stop bit is sent.
- Edge and bit counters are held at 0 whenever the FSM is in IDLE.

Optional Feature:
- Macro UART_TX_TWO_STOP_EN.
- Defined: STOP lasts 2 bit times (2P cycles); frame length (11 + PAR_EN) × P.
- Undefined: single stop bit as above.
- Port list is identical in both builds.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE/START/DATA/PARITY/STOP).
  - PAR_EVEN=0, PAR_ODD=1.
  - UART_IDLE_LEVEL=1.
  - Default DATA_WIDTH and PRESCALE_WIDTH constants, reused by the receiver.
- One sub-module, uart_tx_baud_counter:
  - Inputs: enable, prescale.
  - Outputs: edge_cnt, bit_cnt, bit_done pulse (high in the last cycle of each bit).
  - Clears when enable=0.
- The FSM, shift register and parity logic stay in the top module.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5, one-cycle Data_Valid → Busy high 88 cycles. TX_OUT per 8-cycle slot: 0,1,0,1,0,0,1,0,1,0(parity),1.
- Prescale=16, PAR_EN=0, P_DATA=0xFF → 0 then nine 1-bits. Busy high exactly 160 cycles, then idle high.
- Prescale=8, PAR_EN=1, PAR_TYP=1, P_DATA=0x01 → parity slot=0. Repeat with 0x03 → parity slot=1.
- Data_Valid held high continuously with 0x55 then 0x0F: second byte is accepted only in the first IDLE cycle after the stop bit. No change while Busy; P_DATA/Prescale changes mid-frame are ignored.
- RST pulled low during DATA bit 3 → TX_OUT=1 and Busy=0 asynchronously. The next request 0x3C after release sends a complete, correct frame.
- UART_TX_TWO_STOP_EN defined, Prescale=8, PAR_EN=0 → TX_OUT high for 16 stop cycles; Busy high for 88 cycles total.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity encodings, line level
// and default widths used by both the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam logic PAR_EVEN        = 1'b0;
    localparam logic PAR_ODD         = 1'b1;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    localparam int UART_DATA_WIDTH     = 8;
    localparam int UART_PRESCALE_WIDTH = 6;
    localparam int UART_BIT_CNT_WIDTH  = 4;

endpackage

// File: rtl/uart_tx_baud_counter.sv
// Bit-time generator for the UART transmitter: edge counter per bit,
// frame bit index, and a pulse in the last cycle of every bit.
module uart_tx_baud_counter
    import uart_pkg::*;
#(
    parameter int PRESCALE_WIDTH = UART_PRESCALE_WIDTH,
    parameter int BIT_WIDTH      = UART_BIT_CNT_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic [PRESCALE_WIDTH-1:0] edge_cnt,
    output logic [BIT_WIDTH-1:0]      bit_cnt,
    output logic                      bit_done
);

    logic [PRESCALE_WIDTH-1:0] edge_q;
    logic [PRESCALE_WIDTH-1:0] last_edge;
    logic [BIT_WIDTH-1:0]      bit_q;

    // Prescale of 0 or 1 both mean a single cycle per bit
    assign last_edge = (prescale > PRESCALE_WIDTH'(1))
                     ? prescale - PRESCALE_WIDTH'(1)
                     : '0;

    assign bit_done = enable && (edge_q >= last_edge);
    assign edge_cnt = enable ? edge_q : '0;
    assign bit_cnt  = enable ? bit_q  : '0;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else if (!enable) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else if (bit_done) begin
            edge_q <= '0;
            bit_q  <= bit_q + BIT_WIDTH'(1);
        end else begin
            edge_q <= edge_q + PRESCALE_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start / data LSB first / optional parity / stop.
// Define UART_TX_TWO_STOP_EN for a two-bit-time stop period.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = UART_DATA_WIDTH,
    parameter int PRESCALE_WIDTH = UART_PRESCALE_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      Busy
);

    localparam int BW = $clog2(DATA_WIDTH + 5);

    uart_state_t               state;
    logic [DATA_WIDTH-1:0]     shift_q;
    logic                      par_en_q;
    logic                      par_bit_q;
    logic                      par_calc;
    logic [PRESCALE_WIDTH-1:0] presc_q;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_unused;
    logic [BW-1:0]             bit_cnt;
    logic [BW-1:0]             stop_last;
    logic                      bit_done;

    uart_tx_baud_counter #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .BIT_WIDTH      (BW)
    ) u_baud (
        .CLK      (CLK),
        .RST      (RST),
        .enable   (state != IDLE),
        .prescale (presc_q),
        .edge_cnt (edge_cnt_unused),
        .bit_cnt  (bit_cnt),
        .bit_done (bit_done)
    );

    // Frame bit index: start=0, data=1..DATA_WIDTH, then parity, then stop
`ifdef UART_TX_TWO_STOP_EN
    assign stop_last = BW'(DATA_WIDTH + 2) + BW'(par_en_q);
`else
    assign stop_last = BW'(DATA_WIDTH + 1) + BW'(par_en_q);
`endif

    always_comb begin
        par_calc = ^P_DATA;
        unique case (PAR_TYP)
            PAR_EVEN: par_calc = ^P_DATA;
            PAR_ODD:  par_calc = ~^P_DATA;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            TX_OUT    <= UART_IDLE_LEVEL;
            Busy      <= 1'b0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            presc_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    TX_OUT <= UART_IDLE_LEVEL;
                    Busy   <= 1'b0;
                    if (Data_Valid) begin
                        shift_q   <= P_DATA;
                        par_en_q  <= PAR_EN;
                        par_bit_q <= par_calc;
                        presc_q   <= Prescale;
                        state     <= START;
                        TX_OUT    <= 1'b0;
                        Busy      <= 1'b1;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        TX_OUT  <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_cnt == BW'(DATA_WIDTH)) begin
                            if (par_en_q) begin
                                state  <= PARITY;
                                TX_OUT <= par_bit_q;
                            end else begin
                                state  <= STOP;
                                TX_OUT <= UART_IDLE_LEVEL;
                            end
                        end else begin
                            TX_OUT  <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state  <= STOP;
                        TX_OUT <= UART_IDLE_LEVEL;
                    end
                end
                STOP: begin
                    if (bit_done && bit_cnt == stop_last) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    TX_OUT <= UART_IDLE_LEVEL;
                    Busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: a request tracker pushes expected
// frames from a bit-list model, a line monitor checks every bit slot.
module tb_uart_tx_frame;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] P_DATA = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd0;
    logic       TX_OUT;
    logic       Busy;

    always #5 CLK = ~CLK;

    uart_tx_frame dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          p;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic samples[$];
    bit   in_frame = 1'b0;
    bit   abort_pending = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input bit ok,
                         input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Line picture of one frame, built straight from the framing rules
    function automatic exp_t model(input logic [7:0] d, input logic pe,
                                   input logic pt, input logic [5:0] ps,
                                   input int acc);
        exp_t e;
        int   n;
        int   ones;
        e.bits = '0;
        n = 0;
        e.bits[n] = 1'b0;
        n = n + 1;
        for (int i = 0; i < 8; i++) begin
            e.bits[n] = d[i];
            n = n + 1;
        end
        if (pe) begin
            ones = $countones(d);
            e.bits[n] = ((ones % 2) == 1) ^ pt;
            n = n + 1;
        end
        e.bits[n] = 1'b1;
        n = n + 1;
`ifdef UART_TX_TWO_STOP_EN
        e.bits[n] = 1'b1;
        n = n + 1;
`endif
        e.nbits = n;
        e.p = (ps < 6'd2) ? 1 : int'(ps);
        e.acc = acc;
        return e;
    endfunction

    // Request tracker: a request present while the line is not busy is taken
    always @(negedge CLK) begin
        #1;
        if (RST && Data_Valid && !Busy)
            exp_q.push_back(model(P_DATA, PAR_EN, PAR_TYP, Prescale, cyc));
    end

    // Line monitor
    always @(negedge CLK) begin
        if (in_frame) begin
            if (Busy) begin
                samples.push_back(TX_OUT);
            end else begin
                in_frame = 1'b0;
                if (abort_pending) begin
                    abort_pending = 1'b0;
                end else begin
                    check("busy_len", samples.size() == cur.nbits * cur.p,
                          samples.size(), cur.nbits * cur.p);
                    for (int k = 0; k < cur.nbits; k++) begin
                        int bad;
                        int act;
                        int idx;
                        bad = -1;
                        act = int'(cur.bits[k]);
                        for (int j = 0; j < cur.p; j++) begin
                            idx = k * cur.p + j;
                            if (bad < 0) begin
                                if (idx >= samples.size()) begin
                                    bad = j;
                                    act = 2;
                                end else if (samples[idx] !== cur.bits[k]) begin
                                    bad = j;
                                    act = int'(samples[idx]);
                                end
                            end
                        end
                        check($sformatf("slot%0d", k), bad < 0,
                              act, int'(cur.bits[k]));
                    end
                    check("idle_high", TX_OUT === 1'b1, int'(TX_OUT), 1);
                end
            end
        end else if (Busy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame", 1'b0, 1, 0);
            end else begin
                cur = exp_q.pop_front();
                in_frame = 1'b1;
                samples.delete();
                samples.push_back(TX_OUT);
                check("accept_latency", cyc == cur.acc + 1, cyc, cur.acc + 1);
            end
        end
    end

    task automatic scramble();
        P_DATA   = 8'($urandom);
        Prescale = 6'($urandom);
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
    endtask

    task automatic wait_idle(input int budget, input bit scr);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge CLK);
            n++;
            if (!Busy) break;
            if (scr) scramble();
        end
        check("idle_reached", !Busy, int'(Busy), 0);
    endtask

    task automatic send(input logic [7:0] d, input logic pe,
                        input logic pt, input logic [5:0] ps);
        @(negedge CLK);
        P_DATA = d;
        PAR_EN = pe;
        PAR_TYP = pt;
        Prescale = ps;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        wait_idle(1000, 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        check("reset_tx", TX_OUT === 1'b1, int'(TX_OUT), 1);
        check("reset_busy", Busy === 1'b0, int'(Busy), 0);
        RST = 1'b1;
        @(negedge CLK);

        send(8'hA5, 1'b1, 1'b0, 6'd8);
        send(8'hFF, 1'b0, 1'b0, 6'd16);
        send(8'h01, 1'b1, 1'b1, 6'd8);
        send(8'h03, 1'b1, 1'b1, 6'd8);

        // Request held high across two frames, inputs changed mid-frame
        @(negedge CLK);
        P_DATA = 8'h55;
        PAR_EN = 1'b0;
        Prescale = 6'd4;
        Data_Valid = 1'b1;
        @(negedge CLK);
        P_DATA = 8'h0F;
        PAR_EN = 1'b1;
        PAR_TYP = 1'b0;
        Prescale = 6'd3;
        wait_idle(1000, 1'b0);
        @(negedge CLK);
        Data_Valid = 1'b0;
        wait_idle(1000, 1'b0);

        // Asynchronous reset in the middle of data bit 3
        @(negedge CLK);
        P_DATA = 8'hC3;
        PAR_EN = 1'b0;
        Prescale = 6'd8;
        Data_Valid = 1'b1;
        @(negedge CLK);
        Data_Valid = 1'b0;
        repeat (34) @(negedge CLK);
        abort_pending = 1'b1;
        #3;
        RST = 1'b0;
        #1;
        check("abort_tx", TX_OUT === 1'b1, int'(TX_OUT), 1);
        check("abort_busy", Busy === 1'b0, int'(Busy), 0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        send(8'h3C, 1'b1, 1'b0, 6'd8);

        send(8'h00, 1'b1, 1'b1, 6'd1);
        send(8'h80, 1'b1, 1'b0, 6'd0);
        repeat (25)
            send(8'($urandom), 1'($urandom), 1'($urandom),
                 6'($urandom_range(0, 12)));

        repeat (5) @(negedge CLK);
        check("scoreboard_empty", exp_q.size() == 0 && !in_frame,
              exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
